// File: rtl/tty_pkg.sv
// rtl/tty_pkg.sv - shared types and constants for the console teletype receiver
package tty_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tty_state_e;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

  // Positions of the IOP pulses within the packed {iop4, iop2, iop1} vector
  localparam int IOP_KSF = 0;
  localparam int IOP_KCC = 1;
  localparam int IOP_KRS = 2;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser that resets to 1 (mark/idle)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m706_tty_rx.sv
// rtl/m706_tty_rx.sv - teletype keyboard/reader receiver with KSF/KCC/KRS/KRB IOTs
module m706_tty_rx #(
  parameter int OVERSAMPLE = tty_pkg::OVERSAMPLE_DEF,
  parameter int DATA_BITS  = tty_pkg::DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 line_in,
  input  logic                 dev_sel,
  input  logic                 iop1,
  input  logic                 iop2,
  input  logic                 iop4,
  output logic                 skip,
  output logic                 ac_clear,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 int_req,
  output logic                 flag,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 reader_run,
  output logic                 active
);
  import tty_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  tty_state_e           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] buffer;
  logic                 line_s;
  logic [2:0]           iop;
  logic                 kcc;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (line_in),
    .q     (line_s)
  );

  assign iop      = {iop4, iop2, iop1};
  assign kcc      = dev_sel & iop[IOP_KCC];
  assign skip     = dev_sel & iop[IOP_KSF] & flag;
  assign ac_clear = kcc;
  assign data_out = (dev_sel & iop[IOP_KRS]) ? buffer : '0;
  assign int_req  = flag;
  assign active   = (state != IDLE);

  // The KCC clear is written first so a same-edge character load or start
  // detect overrides it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      buffer      <= '0;
      flag        <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      reader_run  <= 1'b0;
    end else begin
      if (kcc) begin
        flag        <= 1'b0;
        framing_err <= 1'b0;
        overrun     <= 1'b0;
        reader_run  <= 1'b1;
      end
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (!line_s) begin
              state      <= START;
              tick_cnt   <= '0;
              reader_run <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt == MID_TICK) begin
              if (!line_s) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              shreg    <= {line_s, shreg[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              buffer      <= shreg;
              flag        <= 1'b1;
              framing_err <= ~line_s;
              overrun     <= flag;
              tick_cnt    <= '0;
              state       <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
